// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants for the general-purpose register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default register width, address
//                                          width and read port count
//   RESET_BIT                            : bit value replicated into every
//                                          register word at reset
//   EN_LVL / DIS_LVL                     : enable / disable logic levels
package gpr_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  localparam logic RESET_BIT = 1'b0;

  localparam logic EN_LVL  = 1'b1;
  localparam logic DIS_LVL = 1'b0;

endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register pending (busy) tracking for gpr_mp.
// Build option: macro GPR_MP_SCOREBOARD_EN. When it is defined the busy
// flops exist. When it is undefined the issue inputs are ignored and both
// outputs are tied to zero.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   iss_en, iss_addr      issue strobe that marks iss_addr pending
//   wrN_en, wrN_addr      write ports; a write clears the busy bit
//   rd_addr               packed read addresses, NUM_RD x ADDR_W
//   rd_busy               per read port: pending and not written this cycle
//   busy_vec              registered busy bit per register
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

`ifdef GPR_MP_SCOREBOARD_EN
  logic [DEPTH-1:0]  busy_d, busy_q;
  logic [ADDR_W-1:0] ra;

  // Clears first and the issue last, so a same-cycle issue and write to one
  // register leaves it busy for the newly issued producer.
  always_comb begin
    busy_d = busy_q;
    if (rst) begin
      busy_d = '0;
    end else begin
      if (wr0_en == EN_LVL) busy_d[wr0_addr] = DIS_LVL;
      if (wr1_en == EN_LVL) busy_d[wr1_addr] = DIS_LVL;
      if (iss_en == EN_LVL) busy_d[iss_addr] = EN_LVL;
    end
    if (ZERO_REG != 0) busy_d[0] = DIS_LVL;
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  // A register written this cycle is bypassed to the reader, so it is not busy.
  always_comb begin
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rd_busy[k] = busy_q[ra] &
                   ~((wr0_en && (wr0_addr == ra)) || (wr1_en && (wr1_addr == ra)));
    end
  end

  assign busy_vec = busy_q;
`else
  logic unused_sb;
  assign unused_sb = ^{clk, rst, iss_en, iss_addr, wr0_en, wr0_addr,
                       wr1_en, wr1_addr, rd_addr};
  assign rd_busy   = '0;
  assign busy_vec  = '0;
`endif

endmodule

// File: rtl/gpr_mp.sv
// gpr_mp: multi-ported general-purpose register file. It has two write ports
// (wr0 has priority over wr1), NUM_RD combinational read ports with
// zero-latency write bypass, and an optional busy scoreboard.
// Build option: macro GPR_MP_SCOREBOARD_EN enables the scoreboard inside
// gpr_scoreboard. Without it, rd_busy and busy_vec read as zero.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wr0_en/wr0_addr/wr0_data      write port 0 (higher priority)
//   wr1_en/wr1_addr/wr1_data      write port 1
//   rd_addr / rd_data             packed read addresses / read data
//   iss_en / iss_addr             scoreboard issue strobe and register
//   rd_busy / busy_vec            pending flags per read port / per register
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wr0_ok, wr1_ok;
  logic [ADDR_W-1:0] ra;

  assign wr0_ok = (wr0_en == EN_LVL) && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign wr1_ok = (wr1_en == EN_LVL) && !((ZERO_REG != 0) && (wr1_addr == '0));

  // wr1 is applied before wr0, so wr0 wins when both target one register.
  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = {DATA_W{RESET_BIT}};
    end else begin
      if (wr1_ok) regs_d[wr1_addr] = wr1_data;
      if (wr0_ok) regs_d[wr0_addr] = wr0_data;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // The bypass ignores rst. During reset the write ports still forward, and
  // stored values keep reading as they were until the reset edge.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (ra == '0))
        rd_data[k*DATA_W +: DATA_W] = '0;
      else if (wr0_en && (wr0_addr == ra))
        rd_data[k*DATA_W +: DATA_W] = wr0_data;
      else if (wr1_en && (wr1_addr == ra))
        rd_data[k*DATA_W +: DATA_W] = wr1_data;
      else
        rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
    end
  end

  gpr_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .wr0_en  (wr0_en),
    .wr0_addr(wr0_addr),
    .wr1_en  (wr1_en),
    .wr1_addr(wr1_addr),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy),
    .busy_vec(busy_vec)
  );

endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: self-checking bench for gpr_mp. It runs one instance with
// ZERO_REG=1 and one with ZERO_REG=0 on shared stimulus, and checks both
// against an array-based reference model.
module tb_gpr_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;
`ifdef GPR_MP_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic wr0_en, wr1_en, iss_en;
  logic [AW-1:0] wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_nz;
  logic [NR-1:0]    rd_busy, rd_busy_nz;
  logic [DEPTH-1:0] busy_vec, busy_vec_nz;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [DW-1:0] m_z  [DEPTH];
  logic [DW-1:0] m_nz [DEPTH];
  bit            m_busy [DEPTH];

  always #5 clk = ~clk;

  gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_busy(rd_busy), .busy_vec(busy_vec)
  );

  gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_busy(rd_busy_nz), .busy_vec(busy_vec_nz)
  );

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit zero);
    if (zero && a == 0) return '0;
    if (wr0_en && wr0_addr == a) return wr0_data;
    if (wr1_en && wr1_addr == a) return wr1_data;
    return zero ? m_z[a] : m_nz[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (!SB) return 1'b0;
    return m_busy[a] && !((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a));
  endfunction

  function automatic logic [DEPTH-1:0] exp_vec();
    logic [DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[i] = SB && m_busy[i];
    return v;
  endfunction

  // Advance one clock edge, updating the model from the inputs held at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_z[i] = '0; m_nz[i] = '0; m_busy[i] = 1'b0;
      end
    end else begin
      if (wr1_en) begin
        m_nz[wr1_addr] = wr1_data;
        if (wr1_addr != 0) m_z[wr1_addr] = wr1_data;
        m_busy[wr1_addr] = 1'b0;
      end
      if (wr0_en) begin
        m_nz[wr0_addr] = wr0_data;
        if (wr0_addr != 0) m_z[wr0_addr] = wr0_data;
        m_busy[wr0_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); rd_addr = '0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; set_rd(0, 5'd5); set_rd(1, 5'd31);
    #1;
    chk_cnt++;
    if (busy_vec !== '0) $display("FAIL reset_busy_vec got=%h exp=0", busy_vec);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data !== '0) $display("FAIL reset_rd_data got=%h exp=0", rd_data);
    else pass_cnt++;
    chk_cnt++;
    if (rd_busy !== '0) $display("FAIL reset_rd_busy got=%b exp=0", rd_busy);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    idle(); wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234_5678;
    tick();
    idle(); set_rd(0, 5'd5);
    #1;
    chk_cnt++;
    if (rd_data[0 +: DW] !== 32'h1234_5678)
      $display("FAIL write_read got=%h exp=12345678", rd_data[0 +: DW]);
    else pass_cnt++;
  endtask

  task automatic test_write_priority();
    idle(); set_rd(1, 5'd7);
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAA_0000;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h0000_5555;
    #1;
    chk_cnt++;
    if (rd_data[DW +: DW] !== 32'hAAAA_0000)
      $display("FAIL prio_bypass got=%h exp=aaaa0000", rd_data[DW +: DW]);
    else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++;
    if (rd_data[DW +: DW] !== 32'hAAAA_0000)
      $display("FAIL prio_stored got=%h exp=aaaa0000", rd_data[DW +: DW]);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    idle(); set_rd(0, 5'd0);
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    #1;
    chk_cnt++;
    if (rd_data[0 +: DW] !== 32'h0) $display("FAIL zero_bypass got=%h exp=0", rd_data[0 +: DW]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data_nz[0 +: DW] !== 32'hFFFF_FFFF)
      $display("FAIL nz_bypass got=%h exp=ffffffff", rd_data_nz[0 +: DW]);
    else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++;
    if (rd_data[0 +: DW] !== 32'h0) $display("FAIL zero_stored got=%h exp=0", rd_data[0 +: DW]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data_nz[0 +: DW] !== 32'hFFFF_FFFF)
      $display("FAIL nz_stored got=%h exp=ffffffff", rd_data_nz[0 +: DW]);
    else pass_cnt++;
  endtask

  task automatic test_bypass_busy();
    idle(); iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    idle(); set_rd(0, 5'd3);
    #1;
    chk_cnt++;
    if (busy_vec[3] !== SB) $display("FAIL issue_busy got=%b exp=%b", busy_vec[3], SB);
    else pass_cnt++;
    chk_cnt++;
    if (rd_busy[0] !== SB) $display("FAIL issue_rd_busy got=%b exp=%b", rd_busy[0], SB);
    else pass_cnt++;
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h42;
    #1;
    chk_cnt++;
    if (rd_busy[0] !== 1'b0) $display("FAIL bypass_not_busy got=%b exp=0", rd_busy[0]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data[0 +: DW] !== 32'h42) $display("FAIL bypass_data got=%h exp=42", rd_data[0 +: DW]);
    else pass_cnt++;
    tick();
    idle();
    #1;
    chk_cnt++;
    if (busy_vec[3] !== 1'b0) $display("FAIL write_clears got=%b exp=0", busy_vec[3]);
    else pass_cnt++;
  endtask

  task automatic test_issue_write_same();
    idle(); iss_en = 1'b1; iss_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
    tick();
    idle(); set_rd(0, 5'd9);
    #1;
    chk_cnt++;
    if (busy_vec[9] !== SB) $display("FAIL set_wins got=%b exp=%b", busy_vec[9], SB);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data[0 +: DW] !== 32'h99) $display("FAIL set_wins_data got=%h exp=99", rd_data[0 +: DW]);
    else pass_cnt++;
    // a repeated issue to a register that is already busy keeps it busy
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    #1;
    chk_cnt++;
    if (busy_vec[9] !== SB) $display("FAIL reissue_busy got=%b exp=%b", busy_vec[9], SB);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [DEPTH-1:0] full;
    for (int a = 1; a < DEPTH; a++) begin
      idle();
      wr0_en = 1'b1; wr0_addr = AW'(a); wr0_data = $urandom | 32'h1;
      iss_en = 1'b1; iss_addr = AW'(a);
      tick();
    end
    idle();
    #1;
    full = {{(DEPTH-1){SB}}, 1'b0};
    chk_cnt++;
    if (busy_vec !== full) $display("FAIL fill_busy got=%h exp=%h", busy_vec, full);
    else pass_cnt++;
    // during reset the bypass still forwards and stored values are pre-reset
    rst = 1'b1; wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'hDEAD_BEEF;
    iss_en = 1'b1; iss_addr = 5'd6;
    set_rd(0, 5'd5); set_rd(1, 5'd4);
    #1;
    chk_cnt++;
    if (rd_data[0 +: DW] !== m_z[5])
      $display("FAIL rst_prereset got=%h exp=%h", rd_data[0 +: DW], m_z[5]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_data[DW +: DW] !== 32'hDEAD_BEEF)
      $display("FAIL rst_bypass got=%h exp=deadbeef", rd_data[DW +: DW]);
    else pass_cnt++;
    tick();
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a)); set_rd(1, AW'(DEPTH-1-a));
      #1;
      chk_cnt++;
      if (rd_data !== '0 || rd_data_nz !== '0)
        $display("FAIL post_rst_data a=%0d got=%h/%h exp=0", a, rd_data, rd_data_nz);
      else pass_cnt++;
    end
    chk_cnt++;
    if (busy_vec !== '0) $display("FAIL post_rst_busy got=%h exp=0", busy_vec);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 39) == 0);
      wr0_en   = $urandom_range(0, 1);
      wr1_en   = $urandom_range(0, 1);
      iss_en   = $urandom_range(0, 2) == 0;
      wr0_addr = AW'($urandom_range(0, 7));
      wr1_addr = AW'($urandom_range(0, 7));
      iss_addr = AW'($urandom_range(0, 7));
      wr0_data = $urandom;
      wr1_data = $urandom;
      for (int p = 0; p < NR; p++) set_rd(p, AW'($urandom_range(0, 7)));
      #1;
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        chk_cnt++;
        if (rd_data[p*DW +: DW] !== exp_rd(a, 1'b1))
          $display("FAIL rand_rd n=%0d p=%0d got=%h exp=%h", n, p, rd_data[p*DW +: DW], exp_rd(a, 1'b1));
        else pass_cnt++;
        chk_cnt++;
        if (rd_data_nz[p*DW +: DW] !== exp_rd(a, 1'b0))
          $display("FAIL rand_rd_nz n=%0d p=%0d got=%h exp=%h", n, p, rd_data_nz[p*DW +: DW], exp_rd(a, 1'b0));
        else pass_cnt++;
        chk_cnt++;
        if (rd_busy[p] !== exp_busy(a))
          $display("FAIL rand_rd_busy n=%0d p=%0d got=%b exp=%b", n, p, rd_busy[p], exp_busy(a));
        else pass_cnt++;
      end
      chk_cnt++;
      if (busy_vec !== exp_vec())
        $display("FAIL rand_busy_vec n=%0d got=%h exp=%h", n, busy_vec, exp_vec());
      else pass_cnt++;
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_z[i] = '0; m_nz[i] = '0; m_busy[i] = 1'b0;
    end
    rd_addr = '0;
    idle();
    test_reset();
    test_write_read();
    test_write_priority();
    test_zero_reg();
    test_bypass_busy();
    test_issue_write_same();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gpr_mp.md
GPR_MP -- requirements
Module: gpr_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wr0_en  in  1  write port 0 enable, active-high, higher priority.
REQ-008 wr0_addr  in  ADDR_W  write port 0 address.
REQ-009 wr0_data  in  DATA_W  write port 0 data.
REQ-010 wr1_en / wr1_addr / wr1_data  in  1 / ADDR_W / DATA_W  write port 1, lower priority.
REQ-011 rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
REQ-013 iss_en  in  1  scoreboard issue strobe: mark iss_addr pending.
REQ-014 iss_addr  in  ADDR_W  register being claimed by an issued instruction.
REQ-015 rd_busy  out  NUM_RD  per-read-port pending flag for rd_addr[k].
REQ-016 busy_vec  out  2**ADDR_W  registered pending bit per register.

Function
REQ-017 Write: on rising edge, wrN_en=1 loads wrN_data into register wrN_addr; both ports to same address -> wr0 value stored.
REQ-018 Read: rd_data[k] = wr0_data if wr0_en and wr0_addr==rd_addr[k]; else wr1_data if wr1_en and address match; else stored value (zero-latency bypass).
REQ-019 ZERO_REG=1: address 0 never written, always reads 0, never bypassed, busy bit 0 forced 0.
REQ-020 Scoreboard: busy[a] set on edge when iss_en and iss_addr==a; cleared when any write port writes a.
REQ-021 Same-cycle issue and write to same register: set wins, busy stays 1 (new producer outstanding).
REQ-022 rd_busy[k] = busy[rd_addr[k]] and not (write to rd_addr[k] this cycle), i.e. bypassed result is not busy.
REQ-023 Issue to already-busy register: busy stays 1, no error.
REQ-024 All outputs are pure functions of state plus current inputs; no extra pipeline stage.

Reset
REQ-025 rst=1 at rising edge clears all registers to 0 and all busy bits to 0; writes and issues that cycle ignored.
REQ-026 During rst, read bypass remains active from write ports (combinational); stored values read as pre-reset until edge.
REQ-027 Reset asserted mid-operation (pending busy bits) discards all pending state with no completion required.

Configuration
REQ-028 Macro GPR_MP_SCOREBOARD_EN: defined -> scoreboard per REQ-020..023; undefined -> iss_en/iss_addr ignored, rd_busy and busy_vec tied to 0, no busy flops.

Structure
REQ-029 Shared package gpr_pkg holds default DATA_W/ADDR_W/NUM_RD, reset word value, and enable/disable level constants.
REQ-030 Scoreboard is sub-module gpr_scoreboard (busy flops, set/clear priority, lookup); storage and bypass stay in gpr_mp.

Verification
REQ-031 After reset, write r5=0x1234_5678 via wr0; next cycle rd_addr[0]=5 -> rd_data[0]=0x1234_5678.
REQ-032 Same cycle wr0(r7=0xAAAA_0000) and wr1(r7=0x0000_5555), rd_addr[1]=7 -> reads 0xAAAA_0000 in-cycle and stored after edge.
REQ-033 wr0 to r0 with 0xFFFF_FFFF, ZERO_REG=1 -> rd_data for r0 = 0 same and next cycle; ZERO_REG=0 -> 0xFFFF_FFFF.
REQ-034 iss_en r3 -> busy_vec[3]=1 next cycle; wr1 r3=0x42 -> rd_busy=0 and rd_data=0x42 same cycle, busy_vec[3]=0 after edge.
REQ-035 iss_en r9 and wr0 r9=0x99 same cycle -> busy_vec[9]=1 after edge, stored r9=0x99.
REQ-036 Fill r1..r31 and busy bits, assert rst one cycle -> all registers read 0, busy_vec=0.
